// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - round-robin channel scanner with per-visit dwell and valid/ready output
//
// Ports:
//   clk      - sole clock, rising-edge active
//   rst_n    - asynchronous active-low reset
//   en       - scan enable; low forces IDLE on the next edge, y and sel hold
//   ch_mask  - bit i includes channel i in the scan, sampled only when choosing a channel
//   d_in     - packed channel inputs, channel i at [i*W +: W]
//   y        - registered sample of the selected channel
//   y_valid  - y holds a sample ready for transfer (high only in DWELL)
//   y_ready  - consumer accept; a transfer is y_valid && y_ready on a rising edge
//   sel      - index of the selected channel
//   wrap     - one-cycle pulse after an advance back to the lowest (or same) channel
//
// Configuration:
//   MUX_DEADTIME_EN - when defined, a one-cycle GAP state (y_valid low, y held)
//                     precedes every DWELL entry, giving break-before-make
//                     switching. When undefined the GAP state does not exist and
//                     channel switches are bubble-free.

module mux_scan_seq #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [N_CH*W-1:0]        d_in,
    output logic [W-1:0]             y,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [$clog2(N_CH)-1:0]  sel,
    output logic                     wrap
);

    localparam int SW = $clog2(N_CH);
    localparam logic [7:0] LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1
`ifdef MUX_DEADTIME_EN
        ,
        S_GAP   = 2'd2
`endif
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    y_n;
    logic [SW-1:0]   sel_n;
    logic [SW-1:0]   nxt;
    logic [SW-1:0]   first;
    logic [7:0]      cnt, cnt_n;
    logic            wrap_n;

    // Channel mux: select W bits of d_in by index.
    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d,
                                          input logic [SW-1:0]     idx);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == SW'(i)) r = d[i*W +: W];
        end
        return r;
    endfunction

    // Lowest set bit of the mask; descending scan so the lowest index wins.
    function automatic logic [SW-1:0] lowest(input logic [N_CH-1:0] m);
        logic [SW-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SW'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, wrapping modulo N_CH. Offset N_CH maps
    // back to cur itself, so a single-bit mask reselects the same channel.
    // Offsets are scanned from largest to smallest so the nearest one wins.
    function automatic logic [SW-1:0] next_after(input logic [N_CH-1:0] m,
                                                 input logic [SW-1:0]   cur);
        logic [SW-1:0] r;
        int            idx;
        r = cur;
        for (int k = N_CH; k >= 1; k--) begin
            idx = int'(cur) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (m[idx]) r = SW'(idx);
        end
        return r;
    endfunction

    assign nxt     = next_after(ch_mask, sel);
    assign first   = lowest(ch_mask);
    assign y_valid = (state == S_DWELL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            y     <= '0;
            sel   <= '0;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            y     <= y_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            wrap  <= wrap_n;
        end
    end

    always_comb begin
        state_n = state;
        y_n     = y;
        sel_n   = sel;
        cnt_n   = cnt;
        wrap_n  = 1'b0;

        if (!en) begin
            // Abandon any pending sample; y and sel keep their last values.
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|ch_mask) begin
                        sel_n = first;
`ifdef MUX_DEADTIME_EN
                        state_n = S_GAP;
`else
                        state_n = S_DWELL;
                        y_n     = pick(d_in, first);
                        cnt_n   = '0;
`endif
                    end
                end
`ifdef MUX_DEADTIME_EN
                S_GAP: begin
                    // Dead cycle over; make the connection to the new channel.
                    state_n = S_DWELL;
                    y_n     = pick(d_in, sel);
                    cnt_n   = '0;
                end
`endif
                S_DWELL: begin
                    if (y_ready) begin
                        if (cnt != LAST) begin
                            cnt_n = cnt + 8'd1;
                            y_n   = pick(d_in, sel);
                        end else if (!(|ch_mask)) begin
                            state_n = S_IDLE;
                        end else begin
                            sel_n  = nxt;
                            wrap_n = (nxt <= sel);
`ifdef MUX_DEADTIME_EN
                            state_n = S_GAP;
`else
                            state_n = S_DWELL;
                            y_n     = pick(d_in, nxt);
                            cnt_n   = '0;
`endif
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux_scan_seq.md
MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
- REQ-001 The module SHALL have parameter N_CH, default 4 (legal 2..16): number of input channels.
- REQ-002 The module SHALL have parameter W, default 8 (legal 1..32): bits per channel.
- REQ-003 The module SHALL have parameter DWELL, default 4 (legal 1..255): accepted samples per channel visit.
- REQ-004 The module SHALL have port clk, input, 1 bit: sole clock, rising-edge active.
- REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 The module SHALL have port en, input, 1 bit: scan enable.
- REQ-007 The module SHALL have port ch_mask, input, N_CH bits: bit i set means channel i is included in the scan.
- REQ-008 The module SHALL have port d_in, input, N_CH*W bits: channel i occupies bits [i*W +: W].
- REQ-009 The module SHALL have port y, output, W bits: registered sample of the selected channel.
- REQ-010 The module SHALL have port y_valid, output, 1 bit: y holds a sample ready for transfer.
- REQ-011 The module SHALL have port y_ready, input, 1 bit: consumer accepts; a transfer is y_valid && y_ready on a rising edge.
- REQ-012 The module SHALL have port sel, output, clog2(N_CH) bits: index of the selected channel.
- REQ-013 The module SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan returns to the lowest enabled channel.

Function
- REQ-014 The FSM SHALL have states IDLE, GAP and DWELL; GAP SHALL be reachable only when MUX_DEADTIME_EN is defined.
- REQ-015 In IDLE, if en && |ch_mask, the block SHALL load sel with the lowest set mask index and go to DWELL, or to GAP when the macro is defined.
- REQ-016 On the edge that enters DWELL, the block SHALL load y from d_in[sel] and set the dwell counter to 0.
- REQ-017 In DWELL, y_valid SHALL be 1.
- REQ-018 In DWELL, y SHALL remain stable while y_valid && !y_ready (stall).
- REQ-019 On a transfer with counter < DWELL-1, the block SHALL increment the counter and reload y from d_in[sel].
- REQ-020 On a transfer with counter == DWELL-1, the block SHALL advance sel to the next set mask bit above sel, wrapping modulo N_CH.
- REQ-021 On that advance, without the macro the block SHALL re-enter DWELL directly, so that y carries the new channel's sample with no bubble.
- REQ-022 On that advance, with the macro the block SHALL go to GAP for exactly one cycle, with y_valid = 0 and y held, then enter DWELL.
- REQ-023 wrap SHALL pulse in the cycle after an advance whose new sel is less than or equal to the old sel.
- REQ-024 When a single mask bit is set, the same channel SHALL be reselected and wrap SHALL pulse on every advance.
- REQ-025 ch_mask SHALL be sampled only when selecting the next channel; mask changes during DWELL SHALL NOT affect the current visit.
- REQ-026 If the mask sampled at channel selection is all zero, the block SHALL go to IDLE.
- REQ-027 When en is deasserted in any state, the block SHALL go to IDLE on the next edge and drop y_valid, discarding any pending sample; y and sel SHALL hold.
- REQ-028 In IDLE and GAP, y_valid SHALL be 0, and wrap SHALL be 0 except for the post-advance pulse.

Reset
- REQ-029 While rst_n = 0, the block SHALL set state = IDLE, y = 0, y_valid = 0, sel = 0, wrap = 0 and counter = 0, asynchronously.
- REQ-030 The block SHALL leave reset on the first rising clk edge after rst_n rises.
- REQ-031 Reset asserted mid-DWELL SHALL abort the visit with no further transfer.

Configuration
- REQ-032 The macro MUX_DEADTIME_EN SHALL enable the one-cycle break-before-make GAP state before every DWELL entry, including the first after IDLE.
- REQ-033 Without MUX_DEADTIME_EN, the GAP state SHALL NOT be synthesised and channel switches SHALL be bubble-free.

Verification
- REQ-034 The bench SHALL cover: N_CH=4, W=8, DWELL=2, mask=4'b1111, y_ready=1, d_in[i]=8'h10+i, no macro -> y sequence 10,10,11,11,12,12,13,13,10; wrap pulses once per pass.
- REQ-035 The bench SHALL cover: the same setup with MUX_DEADTIME_EN -> one y_valid=0 cycle before each channel; 8 transfers span 12 cycles.
- REQ-036 The bench SHALL cover: mask=4'b1010, y_ready toggling 1,0,1,0 -> sel visits 1,3,1; y stable during each stall; exactly DWELL transfers per visit.
- REQ-037 The bench SHALL cover: mask changed to 4'b0000 mid-DWELL on channel 2 -> current visit completes, then IDLE with y_valid=0.
- REQ-038 The bench SHALL cover: mask=4'b0100 -> sel stays 2; wrap pulses after every DWELL transfers.
- REQ-039 The bench SHALL cover: rst_n pulsed low mid-DWELL with y_ready=0 -> y=0, y_valid=0, sel=0 immediately (asynchronous); restart from the lowest mask bit.
